// File: rtl/alu_iterative_exec.sv
// Multi-cycle ALU execution unit: consumes the 3-bit ALUControl code, one op per
// valid/ready handshake. Shifts iterate one bit per cycle; other ops take one cycle.
module alu_iterative_exec #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_SRL  = 3'b100,
    OP_SLT  = 3'b101,
    OP_PASS = 3'b110,
    OP_SLL  = 3'b111
  } alu_op_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] count_q;
  logic               dir_left_q;

  alu_op_e            op;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic               slt_bit;
  logic [WIDTH-1:0]   alu_value;
  logic [WIDTH-1:0]   work_next;
  logic               accept;
  logic               last_step;

  assign op       = alu_op_e'(alu_ctrl);
  assign shamt    = src_b[SHAMT_W-1:0];
  assign is_shift = (op == OP_SRL) || (op == OP_SLL);
  assign slt_bit  = $signed(src_a) < $signed(src_b);
  assign accept   = (state_q == IDLE) && in_valid;
  assign last_step = (state_q == SHIFT) && (count_q == SHAMT_W'(1));

  assign work_next = dir_left_q ? (work_q << 1) : (work_q >> 1);

  // Shift codes evaluate to A here; that value is only used when shamt is zero.
  always_comb begin
    alu_value = '0;
    case (op)
      OP_ADD:  alu_value = src_a + src_b;
      OP_SUB:  alu_value = src_a - src_b;
      OP_AND:  alu_value = src_a & src_b;
      OP_OR:   alu_value = src_a | src_b;
      OP_SLT:  alu_value = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_PASS: alu_value = src_b;
      OP_SRL,
      OP_SLL:  alu_value = src_a;
      default: alu_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_shift && (shamt != '0)) state_d = SHIFT;
          else                           state_d = DONE;
        end
      end
      SHIFT: begin
        if (count_q == SHAMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      work_q     <= '0;
      count_q    <= '0;
      dir_left_q <= 1'b0;
    end else begin
      if (accept) begin
        if (is_shift && (shamt != '0)) begin
          work_q     <= src_a;
          count_q    <= shamt;
          dir_left_q <= alu_ctrl[0];
        end else begin
          result_q <= alu_value;
        end
      end else if (state_q == SHIFT) begin
        work_q  <= work_next;
        count_q <= count_q - SHAMT_W'(1);
        if (last_step) result_q <= work_next;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule
